// File: rtl/pulse_event_detector_pkg.sv
// Shared types and constants for the pulse event detector.
package pulse_pkg;

  localparam int unsigned DataW  = 12;
  localparam int unsigned TsW    = 32;
  localparam int unsigned WidthW = 8;
  localparam int unsigned DROP_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StHoldoff
  } state_e;

  typedef struct packed {
    logic [TsW-1:0]    ts;
    logic [DataW-1:0]  peak;
    logic [WidthW-1:0] width;
  } evt_rec_t;

endpackage

// File: rtl/pulse_event_detector_if.sv
// Event-record valid/ready port of the pulse event detector.
interface pulse_event_detector_if #(
  parameter int unsigned DATA_W  = pulse_pkg::DataW,
  parameter int unsigned TS_W    = pulse_pkg::TsW,
  parameter int unsigned WIDTH_W = pulse_pkg::WidthW
);
  logic               evt_valid;
  logic               evt_ready;
  logic [TS_W-1:0]    evt_ts;
  logic [DATA_W-1:0]  evt_peak;
  logic [WIDTH_W-1:0] evt_width;

  modport master (
    output evt_valid, evt_ts, evt_peak, evt_width,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_ts, evt_peak, evt_width,
    output evt_ready
  );
endinterface

// File: rtl/pulse_event_detector_evt_slot.sv
// Single-entry valid/ready holding register; flags a load request it cannot accept.
module evt_slot #(
  parameter int unsigned RecW = 52
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [RecW-1:0] data_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [RecW-1:0] data_o,
  output logic            drop_o
);
  logic            valid_q, valid_d;
  logic [RecW-1:0] data_q, data_d;
  logic            fire, accept;

  always_comb begin
    fire    = valid_q & ready_i;
    // A transfer in the same cycle frees the slot for the incoming record.
    accept  = load_i & (~valid_q | fire);
    drop_o  = load_i & ~accept;
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pulse_event_detector.sv
// Hysteresis pulse discriminator with holdoff; emits {ts, peak, width} per pulse.
module pulse_event_detector
  import pulse_pkg::*;
#(
  parameter int unsigned DATA_W  = DataW,
  parameter int unsigned TS_W    = TsW,
  parameter int unsigned WIDTH_W = WidthW,
  parameter int unsigned HOLDOFF = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sample_valid,
  input  logic [DATA_W-1:0]      sample,
  input  logic [DATA_W-1:0]      thresh_hi,
  input  logic [DATA_W-1:0]      thresh_lo,
  pulse_event_detector_if.master evt,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   busy
);
  localparam int unsigned HoldW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned RecW  = TS_W + DATA_W + WIDTH_W;

  state_e             state_q, state_d;
  logic [TS_W-1:0]    ts_q, ts_d, cap_ts_q, cap_ts_d;
  logic [DATA_W-1:0]  peak_q, peak_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               busy_q, busy_d;
  logic               evt_done, slot_drop;
  logic [RecW-1:0]    slot_data;

  always_comb begin
    state_d  = state_q;
    cap_ts_d = cap_ts_q;
    peak_d   = peak_q;
    width_d  = width_q;
    hold_d   = hold_q;
    evt_done = 1'b0;
    ts_d     = enable ? ts_q + 1'b1 : ts_q;
    if (!enable) begin
      // Abort: partial pulse is discarded, never offered to the slot.
      state_d = StIdle;
      hold_d  = '0;
    end else if (sample_valid) begin
      unique case (state_q)
        StIdle: begin
          if (sample >= thresh_hi) begin
            state_d  = StPulse;
            cap_ts_d = ts_q;
            peak_d   = sample;
            width_d  = WIDTH_W'(1);
          end
        end
        StPulse: begin
          if (sample < thresh_lo) begin
            evt_done = 1'b1;
            state_d  = (HOLDOFF == 0) ? StIdle : StHoldoff;
            hold_d   = '0;
          end else begin
            if (sample > peak_q) peak_d = sample;
            if (width_q != '1) width_d = width_q + 1'b1;
          end
        end
        StHoldoff: begin
          if (hold_q == HoldW'(HOLDOFF - 1)) begin
            state_d = StIdle;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    drop_d = (slot_drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ts_q     <= '0;
      cap_ts_q <= '0;
      peak_q   <= '0;
      width_q  <= '0;
      hold_q   <= '0;
      drop_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      cap_ts_q <= cap_ts_d;
      peak_q   <= peak_d;
      width_q  <= width_d;
      hold_q   <= hold_d;
      drop_q   <= drop_d;
      busy_q   <= busy_d;
    end
  end

  evt_slot #(
    .RecW (RecW)
  ) u_evt_slot (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (evt_done),
    .data_i  ({cap_ts_q, peak_q, width_q}),
    .ready_i (evt.evt_ready),
    .valid_o (evt.evt_valid),
    .data_o  (slot_data),
    .drop_o  (slot_drop)
  );

  assign {evt.evt_ts, evt.evt_peak, evt.evt_width} = slot_data;
  assign drop_cnt = drop_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_pulse_event_detector.sv
// Directed bench: vector table for single pulse / holdoff, hand sequences for the rest.
module tb_pulse_event_detector;
  import pulse_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic [11:0] thresh_hi = 12'd1000;
  logic [11:0] thresh_lo = 12'd800;
  logic [15:0] drop_cnt;
  logic        busy;

  pulse_event_detector_if #(.DATA_W(12), .TS_W(32), .WIDTH_W(8)) evt_if ();

  pulse_event_detector #(
    .DATA_W  (12),
    .TS_W    (32),
    .WIDTH_W (8),
    .HOLDOFF (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample       (sample),
    .thresh_hi    (thresh_hi),
    .thresh_lo    (thresh_lo),
    .evt          (evt_if.master),
    .drop_cnt     (drop_cnt),
    .busy         (busy)
  );

  always #10 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          xfers = 0;
  logic [31:0] ts_model;
  logic [31:0] drv_ts, exp_ts;

  // Reference timestamp: counts clocks while enable is high.
  always @(posedge clk or negedge rst) begin
    if (!rst) ts_model <= '0;
    else if (enable) ts_model <= ts_model + 1;
  end

  always @(posedge clk) begin
    if (rst && evt_if.evt_valid && evt_if.evt_ready) xfers <= xfers + 1;
  end

  typedef struct {
    logic        sv;
    logic [11:0] smp;
    logic        mark;
    logic        e_valid;
    logic        e_busy;
    logic        chk;
    logic [11:0] e_peak;
    logic [7:0]  e_width;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic sv, int smp, logic mark, logic ev, logic eb, logic chk,
                              int pk, int wd);
    vec_t v;
    v.sv = sv; v.smp = 12'(smp); v.mark = mark; v.e_valid = ev; v.e_busy = eb;
    v.chk = chk; v.e_peak = 12'(pk); v.e_width = 8'(wd);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic sv, input int smp, input logic rdy);
    @(negedge clk);
    enable = en;
    sample_valid = sv;
    sample = 12'(smp);
    evt_if.evt_ready = rdy;
    drv_ts = ts_model;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input logic rdy);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 100, rdy);
  endtask

  task automatic check_rec(input string name, input logic [31:0] ts, input int pk, input int wd);
    check({name, "_valid"}, 32'(evt_if.evt_valid), 32'd1);
    check({name, "_ts"}, evt_if.evt_ts, ts);
    check({name, "_peak"}, 32'(evt_if.evt_peak), 32'(pk));
    check({name, "_width"}, 32'(evt_if.evt_width), 32'(wd));
  endtask

  logic [31:0] ts_a, ts_e;
  int          x0;

  initial begin
    evt_if.evt_ready = 1'b1;
    vecs[0]  = mk(1, 100,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1200, 1, 0, 1, 0, 0, 0);
    vecs[2]  = mk(1, 1500, 0, 0, 1, 0, 0, 0);
    vecs[3]  = mk(0, 4000, 0, 0, 1, 0, 0, 0);
    vecs[4]  = mk(1, 900,  0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(1, 700,  0, 1, 1, 1, 1500, 3);
    vecs[6]  = mk(1, 1200, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(1, 1200, 0, 0, 1, 0, 0, 0);
    vecs[8]  = mk(1, 1200, 0, 0, 1, 0, 0, 0);
    vecs[9]  = mk(1, 1200, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 1200, 1, 0, 1, 0, 0, 0);
    vecs[11] = mk(1, 700,  0, 1, 1, 1, 1200, 1);
    vecs[12] = mk(1, 100,  0, 0, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_ts", evt_if.evt_ts, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single pulse followed by holdoff and a width-1 pulse.
    for (int i = 0; i < 13; i++) begin
      cyc(1'b1, vecs[i].sv, int'(vecs[i].smp), 1'b1);
      if (vecs[i].mark) exp_ts = drv_ts;
      check($sformatf("vec%0d_valid", i), 32'(evt_if.evt_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].chk) check_rec($sformatf("vec%0d", i), exp_ts, int'(vecs[i].e_peak),
                                 int'(vecs[i].e_width));
    end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 100, 1'b1);
    check("holdoff_done_busy", 32'(busy), 32'd0);

    // Back-pressure: first record held, next two dropped.
    cyc(1, 1, 1200, 0); ts_a = drv_ts;
    cyc(1, 1, 1300, 0);
    cyc(1, 1, 700, 0);
    check_rec("bp_a", ts_a, 1300, 2);
    drain(1'b0);
    cyc(1, 1, 1100, 0); cyc(1, 1, 700, 0);
    check("bp_drop1", 32'(drop_cnt), 32'd1);
    drain(1'b0);
    cyc(1, 1, 1100, 0); cyc(1, 1, 700, 0);
    drain(1'b0);
    check("bp_drop2", 32'(drop_cnt), 32'd2);
    check_rec("bp_held", ts_a, 1300, 2);
    x0 = xfers;
    cyc(1, 1, 100, 1);
    check("bp_release_valid", 32'(evt_if.evt_valid), 32'd0);
    cyc(1, 1, 100, 1); cyc(1, 1, 100, 1);
    check("bp_one_xfer", 32'(xfers - x0), 32'd1);

    // Completion coinciding with a transfer from a full slot: no drop.
    cyc(1, 1, 1100, 0); cyc(1, 1, 1150, 0); cyc(1, 1, 700, 0);
    check("simul_d_valid", 32'(evt_if.evt_valid), 32'd1);
    drain(1'b0);
    cyc(1, 1, 1400, 0); ts_e = drv_ts;
    x0 = xfers;
    cyc(1, 1, 700, 1);
    check_rec("simul_e", ts_e, 1400, 1);
    check("simul_drop", 32'(drop_cnt), 32'd2);
    check("simul_xfer", 32'(xfers - x0), 32'd1);
    drain(1'b1);

    // Width saturation.
    cyc(1, 1, 2000, 1); exp_ts = drv_ts;
    for (int i = 1; i < 300; i++) cyc(1, 1, 2000, 1);
    cyc(1, 1, 0, 1);
    check_rec("sat", exp_ts, 2000, 255);
    drain(1'b1);

    // Abort: enable low mid-pulse.
    cyc(1, 1, 1200, 1); cyc(1, 1, 1300, 1);
    check("abort_busy_pre", 32'(busy), 32'd1);
    cyc(0, 1, 1300, 1);
    check("abort_busy", 32'(busy), 32'd0);
    cyc(0, 0, 0, 1); cyc(0, 1, 1500, 1);
    check("abort_no_evt", 32'(evt_if.evt_valid), 32'd0);
    check("abort_drop", 32'(drop_cnt), 32'd2);
    check("abort_no_rearm", 32'(busy), 32'd0);
    cyc(1, 1, 1200, 1); exp_ts = drv_ts;
    cyc(1, 1, 100, 1);
    check_rec("abort_ts_held", exp_ts, 1200, 1);
    drain(1'b1);

    // Asynchronous reset while a record is pending.
    cyc(1, 1, 1200, 0); cyc(1, 1, 700, 0);
    check("prerst_valid", 32'(evt_if.evt_valid), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(evt_if.evt_valid), 32'd0);
    check("arst_ts", evt_if.evt_ts, 32'd0);
    check("arst_peak", 32'(evt_if.evt_peak), 32'd0);
    check("arst_width", 32'(evt_if.evt_width), 32'd0);
    check("arst_drop", 32'(drop_cnt), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_event_detector.md
# pulse_event_detector

Downstream of the analog front-end sampler in `top`, consumes the digitised photon-detector waveform one sample per clock-enable. Detects pulses with a hysteresis discriminator (rising threshold, falling threshold, post-pulse holdoff). Emits one event record per pulse (start timestamp, peak amplitude, width) over a valid/ready port. Counts events dropped because the consumer stalled.

## Interface
- `DATA_W`, 12: sample and threshold width, unsigned.
- `TS_W`, 32: timestamp counter width.
- `WIDTH_W`, 8: pulse-width field width, in samples.
- `HOLDOFF`, 4: valid samples ignored after each pulse ends; 0 permitted.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  detector run; low aborts any pulse in progress.
- `sample_valid`  in  1  `sample` is valid this cycle.
- `sample`  in  DATA_W  ADC code, unsigned.
- `thresh_hi`  in  DATA_W  arm level; a pulse starts when `sample >= thresh_hi`.
- `thresh_lo`  in  DATA_W  release level; a pulse ends when `sample < thresh_lo`.
- `evt_valid`  out  1  event record held on `evt_*`.
- `evt_ready`  in  1  consumer accepts the record this cycle.
- `evt_ts`  out  TS_W  timestamp of the first sample at or above `thresh_hi`.
- `evt_peak`  out  DATA_W  maximum sample within the pulse.
- `evt_width`  out  WIDTH_W  number of samples at or above release, saturating.
- `drop_cnt`  out  16  count of completed pulses discarded, saturating at 0xFFFF.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- Timestamp counter:
  - increments every clk while `enable` is high; holds while low.
  - wraps modulo 2^TS_W.
- FSM states: IDLE, PULSE, HOLDOFF. All transitions are qualified by `sample_valid`, except the abort on `enable` low.
- IDLE:
  - when `sample >= thresh_hi`: go to PULSE.
  - capture ts = current counter, peak = sample, width = 1.
- PULSE, per valid sample:
  - if `sample < thresh_lo`: the event is complete. Offer it to the output slot, then go to HOLDOFF, or to IDLE when HOLDOFF = 0. The terminating sample updates neither peak nor width.
  - otherwise: peak = max(peak, sample); width += 1, saturating at 2^WIDTH_W−1.
- HOLDOFF:
  - counts HOLDOFF valid samples, then returns to IDLE.
  - the sample that completes the count is ignored; re-arming starts on the next valid sample.
- Output slot (single entry):
  - loads if empty, or if `evt_valid && evt_ready` in the same cycle.
  - otherwise the new event is dropped and `drop_cnt` increments.
  - on a load, the slot holds `evt_*` stable until the handshake completes.
- `enable` low:
  - FSM goes to IDLE next cycle; the partial pulse is discarded without counting a drop.
  - the output slot and `drop_cnt` are unaffected.
- Thresholds are sampled live; no inversion check. If `thresh_lo > thresh_hi`, a pulse may end on its second sample.

## Timing
- Reset: every output is 0. FSM is in IDLE, timestamp = 0, holdoff counter = 0.
- Latency: `evt_valid` rises on the clk edge after the cycle carrying the terminating sample (1 cycle).
- Handshake:
  - transfer occurs on a cycle with `evt_valid && evt_ready`.
  - `evt_valid` does not depend combinationally on `evt_ready`.
  - back-to-back records are possible every cycle the slot is reloaded.
- Simultaneous completion and `evt_ready` while full: the old record transfers, the new one loads, and no drop is counted.
- Reset asserted mid-pulse or mid-handshake: immediate clear. No record is emitted.
- `busy` is registered and reflects the FSM state.

## Structure
- Package `pulse_pkg`:
  - FSM state enum.
  - packed event-record typedef {ts, peak, width}.
  - constant `DROP_W = 16`.
- Sub-module `evt_slot`: single-entry valid/ready register with drop indication. Everything else stays in the top module.

## Test plan
- Single pulse:
  - setup: thresh_hi=1000, thresh_lo=800, HOLDOFF=4.
  - stimulus: samples 100, 1200, 1500, 900, 700, with `evt_ready`=1.
  - expect: one event with ts = timestamp of the 1200 sample, peak=1500, width=3; `evt_valid` high for exactly 1 cycle.
- Holdoff:
  - stimulus: after that pulse, samples 1200 ×4, then 1200, 700.
  - expect: the first four are ignored; the next event has width=1.
- Back-pressure:
  - stimulus: `evt_ready`=0; three pulses complete.
  - expect: the first record is held stable; `drop_cnt`=2. After `evt_ready`=1, exactly one transfer.
- Width saturation:
  - setup: WIDTH_W=8.
  - stimulus: 300 consecutive samples of 2000, then 0.
  - expect: `evt_width`=255, peak=2000.
- Abort:
  - stimulus: `enable` dropped mid-pulse.
  - expect: no event, `drop_cnt` unchanged, `busy`=0 next cycle, timestamp held.
- Reset: `rst` low while `evt_valid`=1 clears all outputs asynchronously.
